// File: rtl/ddrdll_pkg.sv
// ddrdll_pkg: shared state/direction types and code limits for the DDRDLL code loop
package ddrdll_pkg;
    typedef enum logic [1:0] {ACQ, SETL, TRK} state_t;
    typedef enum logic {DIR_UP, DIR_DN} dir_t;
    localparam int CODE_W_DEF = 9;
    localparam int CODE_MAX = (1 << CODE_W_DEF) - 1;
endpackage

// File: rtl/ddrdll_lock_det.sv
// ddrdll_lock_det: counts dither reversals to gain LOCK and same-direction runs to lose it
module ddrdll_lock_det
    import ddrdll_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  dir_t dir,
    output logic lock
);
    logic [7:0] rev;
    logic [3:0] loss;
    dir_t       last;
    logic       has_last;

    // the first step after reset only records a direction; it is neither a reversal nor a repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            lock     <= 1'b0;
            rev      <= '0;
            loss     <= '0;
            last     <= DIR_UP;
            has_last <= 1'b0;
        end else if (step) begin
            has_last <= 1'b1;
            last     <= dir;
            if (!lock) begin
                if (has_last && dir != last) begin
                    if (rev == 8'(LOCK_CNT - 1)) begin
                        lock <= 1'b1;
                        rev  <= '0;
                        loss <= '0;
                    end else begin
                        rev <= rev + 8'd1;
                    end
                end else begin
                    rev <= '0;
                end
            end else if (dir == last) begin
                if (loss == 4'(LOSS_CNT - 1)) begin
                    lock <= 1'b0;
                    loss <= '0;
                    rev  <= '0;
                end else begin
                    loss <= loss + 4'd1;
                end
            end else begin
                loss <= '0;
            end
        end
    end
endmodule

// File: rtl/ddrdll_code_ctrl.sv
// ddrdll_code_ctrl: DDRDLL master lock loop stepping a delay code from phase-detector samples
module ddrdll_code_ctrl
    import ddrdll_pkg::*;
#(
    parameter int CODE_W = $clog2(CODE_MAX + 1),
    parameter int SETTLE = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter logic [CODE_W-1:0] CODE_INIT = '0
) (
    input  logic              CLKIN,
    input  logic              RST,
    input  logic              PD_VALID,
    input  logic              PD_LEAD,
    input  logic              FREEZE,
    input  logic              UDDCNTL_N,
    output logic [CODE_W-1:0] CODE,
    output logic              LOCK,
    output logic              CFLAG
);
    state_t            state;
    logic [CODE_W-1:0] code_q;
    logic [3:0]        settle;
    logic              step;
    logic              sat;
    dir_t              dir;

    assign step = !FREEZE && PD_VALID && state != SETL;
    assign dir  = PD_LEAD ? DIR_UP : DIR_DN;
    assign sat  = dir == DIR_UP ? code_q == '1 : code_q == '0;

    // CODE samples code_q before this edge's step, giving one cycle of publish latency
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state  <= ACQ;
            code_q <= CODE_INIT;
            CODE   <= CODE_INIT;
            CFLAG  <= 1'b0;
            settle <= '0;
        end else begin
            if (!UDDCNTL_N && !FREEZE)
                CODE <= code_q;
            if (step) begin
                code_q <= sat ? code_q : dir == DIR_UP ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
                CFLAG  <= sat;
                state  <= SETL;
                settle <= 4'(SETTLE - 1);
            end else if (state == SETL && !FREEZE) begin
                if (settle == '0)
                    state <= LOCK ? TRK : ACQ;
                else
                    settle <= settle - 4'd1;
            end
        end
    end

    ddrdll_lock_det #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) u_lock_det (
        .clk (CLKIN),
        .rst (RST),
        .step(step),
        .dir (dir),
        .lock(LOCK)
    );
endmodule

// File: tb/tb_ddrdll_code_ctrl.sv
// tb_ddrdll_code_ctrl: directed checks of stepping, settle, lock/loss, saturation, freeze, gate, reset
module tb_ddrdll_code_ctrl;
    logic       CLKIN = 1'b0;
    logic       RST, PD_VALID, PD_LEAD, FREEZE, UDDCNTL_N;
    logic [8:0] CODE;
    logic       LOCK, CFLAG;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLKIN = ~CLKIN;

    ddrdll_code_ctrl dut (
        .CLKIN    (CLKIN),
        .RST      (RST),
        .PD_VALID (PD_VALID),
        .PD_LEAD  (PD_LEAD),
        .FREEZE   (FREEZE),
        .UDDCNTL_N(UDDCNTL_N),
        .CODE     (CODE),
        .LOCK     (LOCK),
        .CFLAG    (CFLAG)
    );

    task automatic tick;
        @(posedge CLKIN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic lead);
        PD_VALID = 1'b1;
        PD_LEAD  = lead;
        tick;
        PD_VALID = 1'b0;
    endtask

    task automatic settle;
        repeat (4) tick;
    endtask

    task automatic walk(input logic lead, input int n);
        repeat (n) begin
            step(lead);
            settle;
        end
    endtask

    task automatic do_reset;
        RST = 1'b1;
        PD_VALID = 1'b0;
        PD_LEAD = 1'b0;
        FREEZE = 1'b0;
        UDDCNTL_N = 1'b0;
        tick;
        tick;
        RST = 1'b0;
    endtask

    initial begin
        do_reset;
        chk("rst_code", 32'(CODE), 0);
        chk("rst_lock", 32'(LOCK), 0);
        chk("rst_cflag", 32'(CFLAG), 0);

        // continuous up requests: one step per 5 edges (step edge + 4 settle), CODE one edge late
        PD_VALID = 1'b1;
        PD_LEAD = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            chk("ramp_code", 32'(CODE), k < 2 ? 0 : (k - 2) / 5 + 1);
        end
        chk("ramp_lock", 32'(LOCK), 0);

        // freeze mid-settle: countdown pauses, nothing moves
        tick;
        chk("pre_frz", 32'(CODE), 4);
        FREEZE = 1'b1;
        repeat (10) begin
            tick;
            chk("frz_hold", 32'(CODE), 4);
        end
        FREEZE = 1'b0;
        repeat (4) begin
            tick;
            chk("frz_resume", 32'(CODE), 4);
        end
        tick;
        chk("frz_step", 32'(CODE), 5);

        // update gate closed while three steps happen
        UDDCNTL_N = 1'b1;
        repeat (15) tick;
        chk("gate_hold", 32'(CODE), 5);
        UDDCNTL_N = 1'b0;
        PD_VALID = 1'b0;
        tick;
        chk("gate_open", 32'(CODE), 8);
        settle;

        // saturation at the top
        do_reset;
        walk(1'b1, 511);
        chk("top_code", 32'(CODE), 511);
        chk("top_cflag0", 32'(CFLAG), 0);
        step(1'b1);
        chk("top_cflag", 32'(CFLAG), 1);
        settle;
        chk("top_sat", 32'(CODE), 511);
        step(1'b0);
        chk("top_clr", 32'(CFLAG), 0);
        settle;
        chk("top_dn", 32'(CODE), 510);

        // saturation at zero
        do_reset;
        step(1'b0);
        chk("bot_cflag", 32'(CFLAG), 1);
        settle;
        chk("bot_sat", 32'(CODE), 0);
        step(1'b1);
        chk("bot_clr", 32'(CFLAG), 0);
        settle;
        chk("bot_up", 32'(CODE), 1);

        // lock acquisition dithering 100/101, 8th reversal is a down step
        do_reset;
        walk(1'b1, 102);
        walk(1'b0, 2);
        chk("acq_start", 32'(CODE), 100);
        chk("acq_lock0", 32'(LOCK), 0);
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 0);
            chk("acq_lock", 32'(LOCK), i == 7 ? 1 : 0);
            settle;
            chk("acq_code", 32'(CODE), i % 2 == 0 ? 101 : 100);
        end

        // lock loss after four consecutive down steps
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("loss_lock", 32'(LOCK), i < 3 ? 1 : 0);
            settle;
            chk("loss_code", 32'(CODE), 99 - i);
        end

        // reset while locked at 300 and mid-settle
        do_reset;
        walk(1'b1, 302);
        walk(1'b0, 2);
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 0);
            if (i < 7) settle;
        end
        chk("trk_lock", 32'(LOCK), 1);
        tick;
        chk("trk_code", 32'(CODE), 300);
        RST = 1'b1;
        PD_VALID = 1'b1;
        PD_LEAD = 1'b1;
        tick;
        chk("mrst_code", 32'(CODE), 0);
        chk("mrst_lock", 32'(LOCK), 0);
        chk("mrst_cflag", 32'(CFLAG), 0);
        RST = 1'b0;
        tick;
        chk("mrst_lat", 32'(CODE), 0);
        tick;
        chk("mrst_step", 32'(CODE), 1);
        PD_VALID = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
